// File: rtl/dds_phase_gen.sv
// Phase-accumulator DDS core: a serial 12-cycle shift-add multiply turns a frequency
// index into a tuning word; the accumulator drives a sine ROM address and computed waveforms.
module dds_phase_gen #(
  parameter int ACC_W = 24,
  parameter int K     = 2796
) (
  input  logic        Fg_CLK,
  input  logic        RESETn,
  input  logic [10:0] Address,
  input  logic        FreqChng,
  input  logic [2:0]  Mode,
  output logic [9:0]  SineAddr,
  output logic [7:0]  Wave,
  output logic        Busy,
  output logic        FtwUpd
);

  localparam int         MSB      = ACC_W - 1;
  localparam logic [11:0] K_BITS  = 12'(K);
  localparam logic [3:0]  LAST_BIT = 4'd11;

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state, state_nx;
  logic [10:0]       addr_q, addr_nx;
  logic [10:0]       pend_addr, pend_addr_nx;
  logic              pending, pending_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [23:0]       prod, prod_nx;
  logic [23:0]       ftw, ftw_nx;
  logic [23:0]       addend;
  logic              upd_nx;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ftw_ext;
  logic [7:0]        wave_nx;

  assign Busy    = (state == MUL);
  assign ftw_ext = ACC_W'(ftw);

  // A pulse arriving while busy (including the completion cycle) is parked and
  // started right after the FtwUpd cycle, so Busy dips for exactly one cycle.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    pend_addr_nx = pend_addr;
    pending_nx   = pending;
    cnt_nx       = cnt;
    prod_nx      = prod;
    ftw_nx       = ftw;
    upd_nx       = 1'b0;
    addend       = K_BITS[cnt] ? (24'(addr_q) << cnt) : 24'd0;
    case (state)
      IDLE: begin
        if (FreqChng || pending) begin
          addr_nx    = FreqChng ? Address : pend_addr;
          pending_nx = 1'b0;
          prod_nx    = 24'd0;
          cnt_nx     = 4'd0;
          state_nx   = MUL;
        end
      end
      MUL: begin
        prod_nx = prod + addend;
        if (FreqChng) begin
          pending_nx   = 1'b1;
          pend_addr_nx = Address;
        end
        if (cnt == LAST_BIT) begin
          ftw_nx   = prod + addend;
          upd_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wave_nx = 8'h00;
    case (Mode)
      3'd1:    wave_nx = {8{acc[MSB]}};
      3'd2:    wave_nx = acc[MSB -: 8];
      3'd3:    wave_nx = acc[MSB] ? ~acc[MSB-1 -: 8] : acc[MSB-1 -: 8];
      default: wave_nx = 8'h00;
    endcase
  end

  // The accumulator always adds the FTW held before this edge, keeping phase continuous.
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state     <= IDLE;
      addr_q    <= '0;
      pend_addr <= '0;
      pending   <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      ftw       <= '0;
      acc       <= '0;
      SineAddr  <= '0;
      Wave      <= '0;
      FtwUpd    <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_q    <= addr_nx;
      pend_addr <= pend_addr_nx;
      pending   <= pending_nx;
      cnt       <= cnt_nx;
      prod      <= prod_nx;
      ftw       <= ftw_nx;
      acc       <= acc + ftw_ext;
      SineAddr  <= acc[MSB -: 10];
      Wave      <= wave_nx;
      FtwUpd    <= upd_nx;
    end
  end

endmodule
